cpu: RTL and testbench
======================

# cpu

Single-cycle MIPS32 subset processor: fetches one instruction per clock from an internal instruction memory, executes it and commits register, memory and PC updates on the same rising edge. It is the top of the CPU design; the only ports are clock and reset. Benches preload program, register and data state through fixed hierarchical paths.

## Interface
- INSTR_MEM_SIZE, 32: instruction memory depth in 32-bit words; power of two.
- DATA_MEM_SIZE, 64: data memory depth in 32-bit words; power of two.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; forces PC to 0 while asserted.

## Operation
- Fixed instance and array names, for bench preload and dump:
  - InstructionMemory_0.data[0:INSTR_MEM_SIZE-1]
  - DataMemory_0.data[0:DATA_MEM_SIZE-1]
  - Registers_0.data[0:31]
  - All are 32-bit arrays.
- Fetch:
  - instr = InstructionMemory_0.data[PC[log2(INSTR_MEM_SIZE)+1:2]].
  - Instruction memory is combinational read-only; PC byte addresses above the depth wrap modulo depth.
- Register file:
  - Two combinational read ports and one write port.
  - Write on the rising edge when RegWrite=1 and destination != 0.
  - Reads of $0 return 0 regardless of array content.
  - Read-during-write returns the old value.
- Supported instructions (opcode/funct per MIPS32):
  - R-type: add, sub, and, or, nor, slt, sll, srl.
  - I-type: addi, andi, ori, slti, lw, sw, beq, bne.
  - J-type: j.
- Arithmetic and width rules:
  - add/sub/addi wrap modulo 2^32; no overflow trap.
  - slt/slti compare signed.
  - addi, slti, lw, sw and branch offsets sign-extend imm16; andi/ori zero-extend it.
  - sll/srl use shamt.
- Next PC:
  - beq/bne taken: PC+4+(sext(imm)<<2).
  - j: {PC+4[31:28], target, 2'b00}.
  - Otherwise PC+4.
- Data memory:
  - Word-addressed with index addr[log2(DATA_MEM_SIZE)+1:2]; out-of-range addresses wrap.
  - Combinational read; write on the rising edge when MemWrite=1.
  - Byte offset addr[1:0] ignored.
- Unknown opcode or funct executes as nop: no register or memory write, PC+4.
- Reset resets only the PC; register file and memories keep contents (preloaded by the bench).

## Timing
- Reset asserted: PC=0 immediately (asynchronous); no register or memory write commits while reset is high.
- First instruction completes on the first rising edge after reset deasserts.
- Latency and throughput are one instruction per cycle; every result is visible in state after that edge.
- Reset mid-program: PC returns to 0; already-committed writes persist.
- Branch to self loops indefinitely with no side effects.

## Structure
- Shared package holds:
  - opcode and funct constants
  - ALU operation encoding
  - control-signal bundle typedef (RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, Branch, BranchNe, Jump, ExtZero, ALUOp)
- Sub-modules:
  - InstructionMemory, DataMemory, Registers: instance names above.
  - ALU: natural separate sub-module, combinational, with a zero flag.
  - Control decode: combinational logic inside cpu.

## Test plan
- Registers preloaded data[i]=i; add $3,$1,$2 then sub $4,$5,$1 -> after 2 edges $3=3, $4=4; slt $6,$5,$1 -> $6=0.
- sw $7,0($8) then lw $9,0($8) with $8=8 -> DataMemory_0.data[2]=7, $9=7.
- beq $1,$1,+2 at PC=0 -> next PC=12; bne $1,$1,+2 -> next PC=4.
- addi $0,$0,5 then add $10,$0,$0 -> $10=0; addi $11,$1,-2 -> $11=0xFFFFFFFF.
- Reset asserted at PC=16 for one half-cycle -> PC=0 immediately; registers unchanged.
- j to word 3 -> PC=12; unknown opcode 0x3F -> PC+4, no state change.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS32 subset core: opcodes, functs,
// ALU operation encoding, the control bundle and the main decoder.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_write;
        logic    branch;
        logic    branch_ne;
        logic    jump;
        logic    ext_zero;
        alu_op_e alu_op;
    } ctrl_t;

    // Anything not recognised leaves every write/branch flag clear, i.e. a nop.
    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        c.alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                case (funct)
                    FN_ADD:  c.alu_op = ALU_ADD;
                    FN_SUB:  c.alu_op = ALU_SUB;
                    FN_AND:  c.alu_op = ALU_AND;
                    FN_OR:   c.alu_op = ALU_OR;
                    FN_NOR:  c.alu_op = ALU_NOR;
                    FN_SLT:  c.alu_op = ALU_SLT;
                    FN_SLL:  c.alu_op = ALU_SLL;
                    FN_SRL:  c.alu_op = ALU_SRL;
                    default: c.reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_SLTI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALU_SLT;
            end
            OP_ANDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.ext_zero  = 1'b1;
                c.alu_op    = ALU_AND;
            end
            OP_ORI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.ext_zero  = 1'b1;
                c.alu_op    = ALU_OR;
            end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                c.branch    = 1'b1;
                c.branch_ne = 1'b1;
                c.alu_op    = ALU_SUB;
            end
            OP_J:    c.jump = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 32-bit ALU; the zero flag drives beq/bne resolution.
module cpu_alu
    import cpu_pkg::*;
(
    input  alu_op_e     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_result,
    output logic        o_zero
);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_NOR: o_result = ~(i_a | i_b);
            ALU_SLT: o_result = {31'd0, $signed(i_a) < $signed(i_b)};
            // Shifts operate on rt (the b operand) by the instruction's shamt.
            ALU_SLL: o_result = i_b << i_shamt;
            ALU_SRL: o_result = i_b >> i_shamt;
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == 32'd0);

endmodule

// File: rtl/cpu_storage.sv
// Architectural storage of the core: instruction ROM, data RAM and register file.
// Array names are fixed so benches can preload and dump them hierarchically.
module InstructionMemory #(
    parameter int SIZE = 32
) (
    input  logic                    i_clk,
    input  logic                    i_we,
    input  logic [$clog2(SIZE)-1:0] i_waddr,
    input  logic [31:0]             i_wdata,
    input  logic [31:0]             i_pc,
    output logic [31:0]             o_instr
);
    localparam int AW = $clog2(SIZE);

    logic [31:0] data [0:SIZE-1];
    logic        w_unused;

    // Load port only; the core ties it off and the fetch path never writes.
    always_ff @(posedge i_clk) begin
        if (i_we) data[i_waddr] <= i_wdata;
    end

    assign o_instr  = data[i_pc[AW+1:2]];
    assign w_unused = ^{i_pc[31:AW+2], i_pc[1:0]};
endmodule

module DataMemory #(
    parameter int SIZE = 64
) (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);
    localparam int AW = $clog2(SIZE);

    logic [31:0]   data [0:SIZE-1];
    logic [AW-1:0] w_idx;
    logic          w_unused;

    // Upper bits wrap and the byte offset is ignored: purely word access.
    assign w_idx    = i_addr[AW+1:2];
    assign w_unused = ^{i_addr[31:AW+2], i_addr[1:0]};

    always_ff @(posedge i_clk) begin
        if (i_we) data[w_idx] <= i_wdata;
    end

    assign o_rdata = data[w_idx];
endmodule

module Registers (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);
    logic [31:0] data [0:31];

    always_ff @(posedge i_clk) begin
        if (i_we && (i_wa != 5'd0)) data[i_wa] <= i_wd;
    end

    // $0 reads as zero whatever the array holds.
    assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : data[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : data[i_ra2];
endmodule

// File: rtl/cpu.sv
// Single-cycle MIPS32 subset core: fetch, decode, execute and commit in one clock.
// Only the PC is reset; storage keeps whatever was preloaded or committed.
module cpu
    import cpu_pkg::*;
#(
    parameter int INSTR_MEM_SIZE = 32,
    parameter int DATA_MEM_SIZE  = 64
) (
    input logic clock,
    input logic reset
);

    logic [31:0] r_pc;
    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_wa;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [25:0] w_target;
    ctrl_t       w_ctrl;
    logic [31:0] w_rd1, w_rd2, w_ext, w_alu_b, w_alu_y, w_mem_rd, w_wd;
    logic        w_zero, w_take, w_reg_we, w_mem_we;
    logic [31:0] w_pc4, w_pc_br, w_pc_next;

    InstructionMemory #(.SIZE(INSTR_MEM_SIZE)) InstructionMemory_0 (
        .i_clk   (clock),
        .i_we    (1'b0),
        .i_waddr ('0),
        .i_wdata (32'd0),
        .i_pc    (r_pc),
        .o_instr (w_instr)
    );

    assign w_op     = w_instr[31:26];
    assign w_rs     = w_instr[25:21];
    assign w_rt     = w_instr[20:16];
    assign w_rd     = w_instr[15:11];
    assign w_shamt  = w_instr[10:6];
    assign w_funct  = w_instr[5:0];
    assign w_imm    = w_instr[15:0];
    assign w_target = w_instr[25:0];

    assign w_ctrl = decode(w_op, w_funct);

    // Nothing commits to storage while reset is held.
    assign w_reg_we = w_ctrl.reg_write & ~reset;
    assign w_mem_we = w_ctrl.mem_write & ~reset;

    Registers Registers_0 (
        .i_clk (clock),
        .i_we  (w_reg_we),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .i_wa  (w_wa),
        .i_wd  (w_wd),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    assign w_ext   = w_ctrl.ext_zero ? {16'd0, w_imm} : {{16{w_imm[15]}}, w_imm};
    assign w_alu_b = w_ctrl.alu_src ? w_ext : w_rd2;

    cpu_alu u_alu (
        .i_op     (w_ctrl.alu_op),
        .i_a      (w_rd1),
        .i_b      (w_alu_b),
        .i_shamt  (w_shamt),
        .o_result (w_alu_y),
        .o_zero   (w_zero)
    );

    DataMemory #(.SIZE(DATA_MEM_SIZE)) DataMemory_0 (
        .i_clk   (clock),
        .i_we    (w_mem_we),
        .i_addr  (w_alu_y),
        .i_wdata (w_rd2),
        .o_rdata (w_mem_rd)
    );

    assign w_wa = w_ctrl.reg_dst ? w_rd : w_rt;
    assign w_wd = w_ctrl.mem_to_reg ? w_mem_rd : w_alu_y;

    assign w_pc4   = r_pc + 32'd4;
    assign w_pc_br = w_pc4 + {w_ext[29:0], 2'b00};
    assign w_take  = w_ctrl.branch & (w_ctrl.branch_ne ? ~w_zero : w_zero);

    always_comb begin
        w_pc_next = w_pc4;
        if (w_ctrl.jump)  w_pc_next = {w_pc4[31:28], w_target, 2'b00};
        else if (w_take)  w_pc_next = w_pc_br;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_pc <= 32'd0;
        else       r_pc <= w_pc_next;
    end

endmodule

// File: tb/tb_cpu.sv
// Bench for the single-cycle core: preloads storage hierarchically, runs short
// programs and compares architectural state against a scoreboard queue.
module tb_cpu;
  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  cpu #(.INSTR_MEM_SIZE(32), .DATA_MEM_SIZE(64)) dut (
    .clock (clock),
    .reset (reset)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = 32'bx;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check(tag, obs, e);
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
    logic [4:0] a, b, d, s;
    a = rs[4:0]; b = rt[4:0]; d = rd[4:0]; s = sh[4:0];
    return {6'h00, a, b, d, s, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input int imm);
    logic [4:0] a, b;
    logic [15:0] k;
    a = rs[4:0]; b = rt[4:0]; k = imm[15:0];
    return {op, a, b, k};
  endfunction

  function automatic logic [31:0] j_ins(input int target);
    logic [25:0] t;
    t = target[25:0];
    return {6'h02, t};
  endfunction

  // Hold reset over a full cycle, then refill storage with known contents.
  task automatic start_test();
    reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 32; i++) begin
      dut.InstructionMemory_0.data[i] = 32'h0;
      dut.Registers_0.data[i] = i;
    end
    for (int i = 0; i < 64; i++) dut.DataMemory_0.data[i] = 32'h0;
  endtask

  task automatic run(input int n);
    reset = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    // R-type arithmetic/logic and shifts
    start_test();
    dut.InstructionMemory_0.data[0] = r_ins(1, 2, 3, 0, 6'h20);   // add $3,$1,$2
    dut.InstructionMemory_0.data[1] = r_ins(5, 1, 4, 0, 6'h22);   // sub $4,$5,$1
    dut.InstructionMemory_0.data[2] = r_ins(5, 1, 6, 0, 6'h2A);   // slt $6,$5,$1
    dut.InstructionMemory_0.data[3] = r_ins(7, 5, 13, 0, 6'h24);  // and $13,$7,$5
    dut.InstructionMemory_0.data[4] = r_ins(8, 3, 14, 0, 6'h25);  // or  $14,$8,$3
    dut.InstructionMemory_0.data[5] = r_ins(0, 0, 15, 0, 6'h27);  // nor $15,$0,$0
    dut.InstructionMemory_0.data[6] = r_ins(0, 3, 16, 4, 6'h00);  // sll $16,$3,4
    dut.InstructionMemory_0.data[7] = r_ins(0, 15, 17, 28, 6'h02);// srl $17,$15,28
    dut.InstructionMemory_0.data[8] = r_ins(1, 5, 18, 0, 6'h2A);  // slt $18,$1,$5
    dut.InstructionMemory_0.data[9] = r_ins(15, 1, 19, 0, 6'h2A); // slt $19,$15,$1
    #1;
    push_exp(32'd0);
    pop_check("pc_in_reset", dut.r_pc);
    run(2);
    push_exp(32'd3); push_exp(32'd4);
    pop_check("add_r3", dut.Registers_0.data[3]);
    pop_check("sub_r4", dut.Registers_0.data[4]);
    run(8);
    push_exp(32'd0); push_exp(32'd5); push_exp(32'd11); push_exp(32'hFFFF_FFFF);
    push_exp(32'd48); push_exp(32'hF); push_exp(32'd1); push_exp(32'd1); push_exp(32'd40);
    pop_check("slt_r6", dut.Registers_0.data[6]);
    pop_check("and_r13", dut.Registers_0.data[13]);
    pop_check("or_r14", dut.Registers_0.data[14]);
    pop_check("nor_r15", dut.Registers_0.data[15]);
    pop_check("sll_r16", dut.Registers_0.data[16]);
    pop_check("srl_r17", dut.Registers_0.data[17]);
    pop_check("slt_r18", dut.Registers_0.data[18]);
    pop_check("slt_neg_r19", dut.Registers_0.data[19]);
    pop_check("pc_after_10", dut.r_pc);

    // Memory, immediates and $0 handling
    start_test();
    dut.InstructionMemory_0.data[0] = i_ins(6'h2B, 8, 7, 0);        // sw $7,0($8)
    dut.InstructionMemory_0.data[1] = i_ins(6'h23, 8, 9, 0);        // lw $9,0($8)
    dut.InstructionMemory_0.data[2] = i_ins(6'h0D, 0, 20, 16'h8000);// ori $20,$0,0x8000
    dut.InstructionMemory_0.data[3] = i_ins(6'h0C, 31, 21, 16'hFFFF);// andi $21,$31,0xFFFF
    dut.InstructionMemory_0.data[4] = i_ins(6'h0A, 1, 22, -1);      // slti $22,$1,-1
    dut.InstructionMemory_0.data[5] = i_ins(6'h0A, 1, 23, 5);       // slti $23,$1,5
    dut.InstructionMemory_0.data[6] = i_ins(6'h08, 0, 0, 5);        // addi $0,$0,5
    dut.InstructionMemory_0.data[7] = r_ins(0, 0, 10, 0, 6'h20);    // add $10,$0,$0
    dut.InstructionMemory_0.data[8] = i_ins(6'h08, 1, 11, -2);      // addi $11,$1,-2
    dut.InstructionMemory_0.data[9] = i_ins(6'h2B, 31, 12, 4);      // sw $12,4($31): addr 35 -> word 8
    run(10);
    push_exp(32'd7); push_exp(32'd7); push_exp(32'h8000); push_exp(32'd31);
    push_exp(32'd0); push_exp(32'd1); push_exp(32'd0); push_exp(32'hFFFF_FFFF); push_exp(32'd12);
    pop_check("sw_mem2", dut.DataMemory_0.data[2]);
    pop_check("lw_r9", dut.Registers_0.data[9]);
    pop_check("ori_zext_r20", dut.Registers_0.data[20]);
    pop_check("andi_r21", dut.Registers_0.data[21]);
    pop_check("slti_neg_r22", dut.Registers_0.data[22]);
    pop_check("slti_r23", dut.Registers_0.data[23]);
    pop_check("r0_add_r10", dut.Registers_0.data[10]);
    pop_check("addi_neg_r11", dut.Registers_0.data[11]);
    pop_check("sw_offset_mem8", dut.DataMemory_0.data[8]);

    // Branches
    start_test();
    dut.InstructionMemory_0.data[0] = i_ins(6'h04, 1, 1, 2);   // beq taken
    run(1);
    push_exp(32'd12);
    pop_check("beq_taken_pc", dut.r_pc);
    start_test();
    dut.InstructionMemory_0.data[0] = i_ins(6'h05, 1, 1, 2);   // bne not taken
    dut.InstructionMemory_0.data[1] = i_ins(6'h04, 1, 2, 5);   // beq not taken
    dut.InstructionMemory_0.data[2] = i_ins(6'h05, 1, 2, -3);  // bne taken back to 0
    run(1);
    push_exp(32'd4);
    pop_check("bne_not_taken_pc", dut.r_pc);
    run(1);
    push_exp(32'd8);
    pop_check("beq_not_taken_pc", dut.r_pc);
    run(1);
    push_exp(32'd0);
    pop_check("bne_back_pc", dut.r_pc);

    // Branch-to-self has no side effects
    start_test();
    dut.InstructionMemory_0.data[0] = i_ins(6'h04, 0, 0, -1);
    run(5);
    push_exp(32'd0); push_exp(32'd5);
    pop_check("self_loop_pc", dut.r_pc);
    pop_check("self_loop_r5", dut.Registers_0.data[5]);

    // Jump, unknown opcode/funct, fetch wrap
    start_test();
    dut.InstructionMemory_0.data[0] = j_ins(3);
    dut.InstructionMemory_0.data[3] = i_ins(6'h3F, 1, 2, 16'h0004);
    dut.InstructionMemory_0.data[4] = r_ins(1, 2, 5, 0, 6'h3F);
    dut.InstructionMemory_0.data[5] = j_ins(33);
    dut.InstructionMemory_0.data[1] = i_ins(6'h08, 0, 25, 7);
    run(1);
    push_exp(32'd12);
    pop_check("j_pc", dut.r_pc);
    run(2);
    push_exp(32'd20); push_exp(32'd2); push_exp(32'd5); push_exp(32'd0); push_exp(32'd0);
    pop_check("unknown_pc", dut.r_pc);
    pop_check("unknown_r2", dut.Registers_0.data[2]);
    pop_check("unknown_fn_r5", dut.Registers_0.data[5]);
    pop_check("unknown_mem1", dut.DataMemory_0.data[1]);
    pop_check("unknown_mem2", dut.DataMemory_0.data[2]);
    run(2);
    push_exp(32'd136); push_exp(32'd7);
    pop_check("wrap_pc", dut.r_pc);
    pop_check("wrap_r25", dut.Registers_0.data[25]);

    // Reset mid-program
    start_test();
    for (int i = 0; i < 8; i++) dut.InstructionMemory_0.data[i] = i_ins(6'h08, 24, 24, 1);
    run(4);
    push_exp(32'd16); push_exp(32'd28);
    pop_check("pre_reset_pc", dut.r_pc);
    pop_check("pre_reset_r24", dut.Registers_0.data[24]);
    reset = 1'b1;
    #1;
    push_exp(32'd0);
    pop_check("async_reset_pc", dut.r_pc);
    #2;
    reset = 1'b0;
    push_exp(32'd28);
    pop_check("reset_keeps_r24", dut.Registers_0.data[24]);
    @(negedge clock);
    push_exp(32'd4); push_exp(32'd29);
    pop_check("post_reset_pc", dut.r_pc);
    pop_check("post_reset_r24", dut.Registers_0.data[24]);
    reset = 1'b1;
    @(negedge clock);
    push_exp(32'd0); push_exp(32'd29);
    pop_check("held_reset_pc", dut.r_pc);
    pop_check("held_reset_no_write", dut.Registers_0.data[24]);
    run(1);
    push_exp(32'd4); push_exp(32'd30);
    pop_check("resume_pc", dut.r_pc);
    pop_check("resume_r24", dut.Registers_0.data[24]);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no completion expected finish before 20000");
    $fatal(1, "timeout");
  end
endmodule
